regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// Parametrised multi-port register file for the pipelined datapath: NUM_RD combinational read ports,
// two write ports, a hard-wired zero register, optional same-cycle write-to-read bypass and a
// per-register pending-write scoreboard for hazard detection. Sits between decode (reads, claims)
// and writeback (writes); it generalises the single-write, two-read file of the single-cycle core.
// PARAMETERS
// DW        64  data width of every register and bus
// AW         5  address width; depth = 2**AW
// NUM_RD     2  number of read ports (1..4)
// ZERO_REG  31  index hard-wired to zero; writes and claims to it are ignored
// BYPASS     1  1: a read sees same-cycle write data; 0: a read sees stored contents only
// PORTS
// Clk      in   1            clock; all state updates on rising edge
// Rst      in   1            synchronous reset, active-high
// RA       in   NUM_RD*AW    read addresses, port p at [p*AW +: AW]
// BusR     out  NUM_RD*DW    read data, port p at [p*DW +: DW]
// RBusy    out  NUM_RD       port p: register RA[p] has a pending (claimed, unwritten) write
// RW0,RW1  in   AW each      write addresses, port 0 / port 1
// BusW0,1  in   DW each      write data
// RegWr    in   2            write enables, bit i for port i
// RC       in   AW           claim address (decode marks destination as pending)
// ClaimEn  in   1            claim strobe
// BEHAVIOUR
// - Clock/reset: one clock Clk; Rst is synchronous, active-high. On a rising edge with Rst=1: all
//   registers <= 0, all scoreboard bits <= 0; writes and claims that cycle are discarded.
// - Outputs after reset: BusR = 0 for every port, RBusy = 0.
// - Write: on rising edge, if RegWr[i] && RWi != ZERO_REG then reg[RWi] <= BusWi. Write latency 1.
// - Both ports, same address, both enabled: port 1 wins; stored value = BusW1.
// - Read: combinational, zero latency, no delay annotations. RA[p]==ZERO_REG -> BusR[p] = 0 always.
// - BYPASS=1: if RA[p] matches an enabled, non-zero write address this cycle, BusR[p] = that write's
//   data (port 1 priority over port 0); else stored value. BYPASS=0: stored value only.
// - Scoreboard: bit per register. Rising edge: write on port i clears bit[RWi]; ClaimEn sets bit[RC].
//   Claim and write to same register in same cycle: set wins (new producer supersedes old).
//   Claim to ZERO_REG ignored; bit[ZERO_REG] is constant 0.
// - RBusy[p] = bit[RA[p]], except BYPASS=1 and an enabled write to RA[p] this cycle -> RBusy[p]=0
//   (data forwarded). BYPASS=0 -> raw bit.
// - Reset mid-operation: pending claims lost; the pipeline is flushed by the same Rst.
// - Unused/out-of-range conditions: none; every AW-bit address is valid storage.
// STRUCTURE
// - Shared header regfile_defs.vh: default DW/AW/ZERO_REG, port-slice index macros.
// - Sub-module regfile_scoreboard (AW, ZERO_REG, NUM_RD): pending bits, set/clear priority, RBusy
//   generation including bypass masking; storage array, write priority and read muxes in top.
// TESTING
// - Reset: write 0xDEAD to r3, then Rst=1 for one edge -> BusR(RA=3) = 0, RBusy = 0.
// - Zero reg: RegWr=01, RW0=31, BusW0=0xFFFF; ClaimEn RC=31 -> BusR(RA=31) = 0, RBusy = 0 always.
// - Dual write collision: RW0=RW1=7, BusW0=0x11, BusW1=0x22 -> next cycle BusR(RA=7) = 0x22.
// - Bypass: r5=0xAA stored; same cycle RegWr=01, RW0=5, BusW0=0xBB, RA=5 -> BusR=0xBB with
//   BYPASS=1, 0xAA with BYPASS=0; next cycle 0xBB in both.
// - Scoreboard: claim r9 -> RBusy(RA=9)=1 next cycle; write r9 -> RBusy=0 in write cycle (BYPASS=1)
//   and after edge; claim+write r9 same cycle -> RBusy stays 1.
// - All ports: NUM_RD=4, write r0..r3 = 0x100+i, read RA={3,2,1,0} -> BusR = {0x103,0x102,0x101,0x100}.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the read-source encoding used by the read muxes and a port-slice helper.
package regfile_mp_pkg;

  localparam int DW_DEFAULT       = 64;
  localparam int AW_DEFAULT       = 5;
  localparam int ZERO_REG_DEFAULT = 31;

  // Where a read port takes its data from in a given cycle
  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_W0    = 2'd1,
    SRC_W1    = 2'd2,
    SRC_ZERO  = 2'd3
  } rd_src_e;

  // Low bit index of port p inside a flattened bus of width-sized fields
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode claims and
// cleared by writebacks, with per-read-port busy flags that are masked when
// the register's data is being forwarded in the same cycle.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RD*AW-1:0] ra,
  input  logic [1:0]        wr_en,
  input  logic [AW-1:0]     rw0,
  input  logic [AW-1:0]     rw1,
  input  logic [AW-1:0]     rc,
  input  logic              claim_en,
  output logic [NUM_RD-1:0] rbusy
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DEPTH-1:0] pend;

  // Clear on writeback, then set on claim so a new producer supersedes the old one
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (wr_en[0]) pend[rw0] <= 1'b0;
      if (wr_en[1]) pend[rw1] <= 1'b0;
      if (claim_en && (rc != ZERO_ADDR)) pend[rc] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
    logic [AW-1:0] ra_p;
    logic          fwd_hit;

    assign ra_p = ra[slice_lo(p, AW) +: AW];

    // Busy is the raw pending bit unless the value is being forwarded right now
    always_comb begin
      fwd_hit = 1'b0;
      if (BYPASS != 0) begin
        fwd_hit = (wr_en[0] && (rw0 == ra_p)) || (wr_en[1] && (rw1 == ra_p));
      end
      rbusy[p] = pend[ra_p] && !fwd_hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined datapath: NUM_RD combinational
// read ports, two write ports (port 1 wins on collision), a hard-wired zero
// register, optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int BYPASS   = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NUM_RD*AW-1:0] RA,
  output logic [NUM_RD*DW-1:0] BusR,
  output logic [NUM_RD-1:0]    RBusy,
  input  logic [AW-1:0]        RW0,
  input  logic [AW-1:0]        RW1,
  input  logic [DW-1:0]        BusW0,
  input  logic [DW-1:0]        BusW1,
  input  logic [1:0]           RegWr,
  input  logic [AW-1:0]        RC,
  input  logic                 ClaimEn
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DW-1:0] mem [DEPTH];
  logic          wr_en0;
  logic          wr_en1;

  assign wr_en0 = RegWr[0] && (RW0 != ZERO_ADDR);
  assign wr_en1 = RegWr[1] && (RW1 != ZERO_ADDR);

  // Storage update; port 1 is written last so it wins an address collision
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en0) mem[RW0] <= BusW0;
      if (wr_en1) mem[RW1] <= BusW1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] ra_p;
    logic [DW-1:0] rd_data;
    rd_src_e       src;

    assign ra_p = RA[slice_lo(p, AW) +: AW];

    // Pick the read source: zero register, forwarded write data, or storage
    always_comb begin
      src = SRC_STORE;
      if (ra_p == ZERO_ADDR) begin
        src = SRC_ZERO;
      end else if ((BYPASS != 0) && wr_en1 && (RW1 == ra_p)) begin
        src = SRC_W1;
      end else if ((BYPASS != 0) && wr_en0 && (RW0 == ra_p)) begin
        src = SRC_W0;
      end
      case (src)
        SRC_ZERO: rd_data = '0;
        SRC_W1:   rd_data = BusW1;
        SRC_W0:   rd_data = BusW0;
        default:  rd_data = mem[ra_p];
      endcase
    end

    assign BusR[slice_lo(p, DW) +: DW] = rd_data;
  end

  regfile_scoreboard #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (Rst),
    .ra       (RA),
    .wr_en    ({wr_en1, wr_en0}),
    .rw0      (RW0),
    .rw1      (RW1),
    .rc       (RC),
    .claim_en (ClaimEn),
    .rbusy    (RBusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 4-read-port bypassing instance and a
// 2-read-port non-bypassing instance share stimulus; expectations are queued
// by the stimulus thread and popped by a monitor on the falling edge.
module tb_regfile_mp;

  typedef struct {
    string       name;
    int          inst;
    int          port;
    logic [63:0] data;
    logic        busy;
  } expItem_t;

  logic        clock;
  logic        reset;
  logic [19:0] raBus;
  logic [4:0]  rw0, rw1, rc;
  logic [63:0] busW0, busW1;
  logic [1:0]  regWr;
  logic        claimEn;

  logic [255:0] busRByp;
  logic [3:0]   rBusyByp;
  logic [127:0] busRNoByp;
  logic [1:0]   rBusyNoByp;

  expItem_t expQ[$];
  int checkCount;
  int errorCount;

  regfile_mp #(.DW(64), .AW(5), .NUM_RD(4), .ZERO_REG(31), .BYPASS(1)) dutByp (
    .Clk(clock), .Rst(reset), .RA(raBus), .BusR(busRByp), .RBusy(rBusyByp),
    .RW0(rw0), .RW1(rw1), .BusW0(busW0), .BusW1(busW1), .RegWr(regWr),
    .RC(rc), .ClaimEn(claimEn)
  );

  regfile_mp #(.DW(64), .AW(5), .NUM_RD(2), .ZERO_REG(31), .BYPASS(0)) dutNoByp (
    .Clk(clock), .Rst(reset), .RA(raBus[9:0]), .BusR(busRNoByp), .RBusy(rBusyNoByp),
    .RW0(rw0), .RW1(rw1), .BusW0(busW0), .BusW1(busW1), .RegWr(regWr),
    .RC(rc), .ClaimEn(claimEn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clock) begin
    while (expQ.size() > 0) begin
      expItem_t it;
      logic [63:0] actData;
      logic        actBusy;
      it = expQ.pop_front();
      if (it.inst == 0) begin
        actData = busRByp[it.port*64 +: 64];
        actBusy = rBusyByp[it.port];
      end else begin
        actData = busRNoByp[it.port*64 +: 64];
        actBusy = rBusyNoByp[it.port];
      end
      checkCount++;
      if (actData !== it.data || actBusy !== it.busy) begin
        errorCount++;
        $display("[TB] FAIL %s inst%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 it.name, it.inst, it.port, actData, actBusy, it.data, it.busy);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic rstIn, input logic [1:0] wrIn,
                               input logic [4:0] w0Addr, input logic [63:0] w0Data,
                               input logic [4:0] w1Addr, input logic [63:0] w1Data,
                               input logic clmIn, input logic [4:0] clmAddr,
                               input logic [19:0] raIn);
    @(posedge clock);
    #1;
    reset   = rstIn;
    regWr   = wrIn;
    rw0     = w0Addr;
    busW0   = w0Data;
    rw1     = w1Addr;
    busW1   = w1Data;
    claimEn = clmIn;
    rc      = clmAddr;
    raBus   = raIn;
  endtask

  task automatic idleRead(input logic [19:0] raIn);
    applyStimulus(1'b0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, raIn);
  endtask

  // Queue an expected response for the current cycle
  task automatic checkOutput(input string name, input int inst, input int port,
                             input logic [63:0] data, input logic busy);
    expItem_t it;
    it.name = name;
    it.inst = inst;
    it.port = port;
    it.data = data;
    it.busy = busy;
    expQ.push_back(it);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1; regWr = 2'b00; rw0 = '0; rw1 = '0; busW0 = '0; busW1 = '0;
    claimEn = 1'b0; rc = '0; raBus = '0;

    applyStimulus(1'b1, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 20'd0);

    // Write r3, bypass instance forwards, stored-only instance still sees 0
    applyStimulus(1'b0, 2'b01, 5'd3, 64'hDEAD, 5'd0, 64'h0, 1'b0, 5'd0, 20'd3);
    checkOutput("wr_r3_fwd", 0, 0, 64'hDEAD, 1'b0);
    checkOutput("wr_r3_nofwd", 1, 0, 64'h0, 1'b0);
    idleRead(20'd3);
    checkOutput("rd_r3", 0, 0, 64'hDEAD, 1'b0);
    checkOutput("rd_r3", 1, 0, 64'hDEAD, 1'b0);

    // Reset clears storage
    applyStimulus(1'b1, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 20'd3);
    idleRead(20'd3);
    checkOutput("reset_r3", 0, 0, 64'h0, 1'b0);
    checkOutput("reset_r3", 1, 0, 64'h0, 1'b0);

    // Zero register ignores writes and claims
    applyStimulus(1'b0, 2'b01, 5'd31, 64'hFFFF, 5'd0, 64'h0, 1'b1, 5'd31, 20'd31);
    checkOutput("zero_same", 0, 0, 64'h0, 1'b0);
    checkOutput("zero_same", 1, 0, 64'h0, 1'b0);
    idleRead(20'd31);
    checkOutput("zero_after", 0, 0, 64'h0, 1'b0);
    checkOutput("zero_after", 1, 0, 64'h0, 1'b0);

    // Dual-write collision: port 1 wins
    applyStimulus(1'b0, 2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 1'b0, 5'd0, 20'd7);
    checkOutput("collide_fwd", 0, 0, 64'h22, 1'b0);
    checkOutput("collide_nofwd", 1, 0, 64'h0, 1'b0);
    idleRead(20'd7);
    checkOutput("collide_stored", 0, 0, 64'h22, 1'b0);
    checkOutput("collide_stored", 1, 0, 64'h22, 1'b0);

    // Bypass of a same-cycle overwrite
    applyStimulus(1'b0, 2'b01, 5'd5, 64'hAA, 5'd0, 64'h0, 1'b0, 5'd0, 20'd0);
    applyStimulus(1'b0, 2'b01, 5'd5, 64'hBB, 5'd0, 64'h0, 1'b0, 5'd0, 20'd5);
    checkOutput("bypass_new", 0, 0, 64'hBB, 1'b0);
    checkOutput("bypass_old", 1, 0, 64'hAA, 1'b0);
    idleRead(20'd5);
    checkOutput("bypass_after", 0, 0, 64'hBB, 1'b0);
    checkOutput("bypass_after", 1, 0, 64'hBB, 1'b0);

    // Scoreboard: claim, then write, then claim+write together
    applyStimulus(1'b0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd9, 20'd9);
    checkOutput("claim_same", 0, 0, 64'h0, 1'b0);
    checkOutput("claim_same", 1, 0, 64'h0, 1'b0);
    idleRead(20'd9);
    checkOutput("claim_pend", 0, 0, 64'h0, 1'b1);
    checkOutput("claim_pend", 1, 0, 64'h0, 1'b1);
    applyStimulus(1'b0, 2'b01, 5'd9, 64'h99, 5'd0, 64'h0, 1'b0, 5'd0, 20'd9);
    checkOutput("wb_mask", 0, 0, 64'h99, 1'b0);
    checkOutput("wb_raw", 1, 0, 64'h0, 1'b1);
    idleRead(20'd9);
    checkOutput("wb_clear", 0, 0, 64'h99, 1'b0);
    checkOutput("wb_clear", 1, 0, 64'h99, 1'b0);
    applyStimulus(1'b0, 2'b10, 5'd0, 64'h0, 5'd9, 64'h77, 1'b1, 5'd9, 20'd9);
    checkOutput("claim_wb_same", 0, 0, 64'h77, 1'b0);
    checkOutput("claim_wb_same", 1, 0, 64'h99, 1'b0);
    idleRead(20'd9);
    checkOutput("claim_wins", 0, 0, 64'h77, 1'b1);
    checkOutput("claim_wins", 1, 0, 64'h77, 1'b1);

    // All read ports: r0..r3 = 0x100+i, then claim r2 while reading
    applyStimulus(1'b0, 2'b11, 5'd0, 64'h100, 5'd1, 64'h101, 1'b0, 5'd0, 20'd0);
    applyStimulus(1'b0, 2'b11, 5'd2, 64'h102, 5'd3, 64'h103, 1'b1, 5'd2, 20'd0);
    idleRead({5'd3, 5'd2, 5'd1, 5'd0});
    for (int p = 0; p < 4; p++) begin
      checkOutput("all_ports", 0, p, 64'h100 + 64'(p), (p == 2));
    end
    checkOutput("all_ports", 1, 0, 64'h100, 1'b0);
    checkOutput("all_ports", 1, 1, 64'h101, 1'b0);

    // Reset mid-operation drops pending claims and data
    applyStimulus(1'b1, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, {5'd3, 5'd2, 5'd1, 5'd0});
    idleRead({5'd3, 5'd2, 5'd1, 5'd9});
    for (int p = 0; p < 4; p++) begin
      checkOutput("mid_reset", 0, p, 64'h0, 1'b0);
    end
    checkOutput("mid_reset", 1, 0, 64'h0, 1'b0);

    idleRead(20'd0);
    @(posedge clock);
    #1;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
